sr_btn_driver: RTL and testbench

- Front-end stage that sits directly upstream of the SR latch lab block.
- Converts two raw, asynchronous, bouncy push-button inputs (set, reset) into a clean S/R drive pair.
- S/R are always a valid one-hot code (S=1,R=0 or S=0,R=1), so the downstream latch never sees the 00 (undefined) or 11 (forbidden) combinations.
- Each button path gets a 2-flop synchronizer, a stability-counter debouncer and a rising-edge detector, followed by a 2-state command FSM.

---
 rtl/sr_btn_driver.sv | 121 ++++++++++++
 tb/tb_sr_btn_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_btn_driver.sv
// sr_btn_driver: turns two raw, bouncy push buttons (set, reset) into a clean,
// always one-hot S/R drive pair for the downstream SR latch.
// Each button passes through a 2-flop synchronizer, a stability-counter
// debouncer and a rising-edge detector. A two-state command FSM then owns S/R.
// Reset is level-sensitive and always wins over set.
module sr_btn_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_rst,
    output logic S,
    output logic R,
    output logic cmd_pulse,
    output logic conflict
);

    // Last count value before the debounced level is allowed to flip.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        RST_HELD = 1'b0,
        SET_HELD = 1'b1
    } state_t;

    // Channel 0 is the set button, channel 1 is the reset button.
    logic [1:0] w_btn;
    logic [1:0] w_db;
    logic [1:0] w_rise;

    assign w_btn = {btn_rst, btn_set};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic             r_sync1;
        logic             r_sync2;
        logic             r_db;
        logic             r_db_d;
        logic [CNT_W-1:0] r_cnt;

        // Two-flop synchronizer for the asynchronous button input.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_btn[g];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
        // differing samples; any agreeing sample restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_db   <= 1'b0;
                r_db_d <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_db_d <= r_db;
                if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_db[g]   = r_db;
        assign w_rise[g] = r_db & ~r_db_d;
    end

    logic   w_set_rise;
    logic   w_rst_rise;
    logic   w_db_rst;
    state_t r_state;
    state_t w_next;
    logic   w_conflict;
    logic   r_cmd_pulse;
    logic   r_conflict;

    assign w_set_rise = w_rise[0];
    assign w_rst_rise = w_rise[1];
    assign w_db_rst   = w_db[1];

    // Next-state logic: reset level dominates; a set press while reset is held
    // is dropped and flagged as a conflict.
    always_comb begin
        w_next     = r_state;
        w_conflict = w_set_rise & w_db_rst;
        case (r_state)
            RST_HELD: if (w_set_rise && !w_db_rst) w_next = SET_HELD;
            SET_HELD: if (w_rst_rise || w_db_rst)  w_next = RST_HELD;
            default:  w_next = RST_HELD;
        endcase
    end

    // State register with the change strobe and conflict strobe registered
    // alongside it, so all outputs move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_HELD;
            r_cmd_pulse <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_pulse <= (w_next != r_state);
            r_conflict  <= w_conflict;
        end
    end

    assign S         = (r_state == SET_HELD);
    assign R         = (r_state == RST_HELD);
    assign cmd_pulse = r_cmd_pulse;
    assign conflict  = r_conflict;

endmodule

// File: tb/tb_sr_btn_driver.sv
// Bench for sr_btn_driver with DEBOUNCE_CYCLES=4.
// Expected S/R changes and conflict strobes are queued with the cycle they
// must appear in; a negedge monitor pops them when the DUT strobes.
module tb_sr_btn_driver;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic clk;
    logic rst_n;
    logic btn_set;
    logic btn_rst;
    logic S;
    logic R;
    logic cmd_pulse;
    logic conflict;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int   at;
        logic s;
    } exp_t;

    exp_t exp_cmd[$];
    int   exp_cfl[$];

    sr_btn_driver #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_set  (btn_set),
        .btn_rst  (btn_rst),
        .S        (S),
        .R        (R),
        .cmd_pulse(cmd_pulse),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: invariant every cycle, and scoreboard pop on each strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            assert (S !== R) else begin
                n_fail++;
                $error("FAIL invariant_S_ne_R: cyc %0d S=%b R=%b, required S!=R", cyc, S, R);
            end
            if (cmd_pulse === 1'b1) begin
                n_tests++;
                if (exp_cmd.size() == 0) begin
                    n_fail++;
                    $error("FAIL unexpected_cmd_pulse: cyc %0d S=%b, required no pulse", cyc, S);
                end else begin
                    exp_t e;
                    e = exp_cmd.pop_front();
                    assert (cyc === e.at) else begin
                        n_fail++;
                        $error("FAIL cmd_cycle: got %0d, expected %0d", cyc, e.at);
                    end
                    n_tests++;
                    assert ({S, R} === {e.s, ~e.s}) else begin
                        n_fail++;
                        $error("FAIL cmd_SR: got %b%b, expected %b%b", S, R, e.s, ~e.s);
                    end
                end
            end
            if (conflict === 1'b1) begin
                n_tests++;
                if (exp_cfl.size() == 0) begin
                    n_fail++;
                    $error("FAIL unexpected_conflict: cyc %0d, required no conflict", cyc);
                end else begin
                    int at;
                    at = exp_cfl.pop_front();
                    assert (cyc === at) else begin
                        n_fail++;
                        $error("FAIL conflict_cycle: got %0d, expected %0d", cyc, at);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_sr(input string tag, input logic s_exp);
        n_tests++;
        assert ({S, R} === {s_exp, ~s_exp}) else begin
            n_fail++;
            $error("FAIL %s: got S=%b R=%b, expected S=%b R=%b", tag, S, R, s_exp, ~s_exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_sr(tag, 1'b0);
        n_tests++;
        assert ({cmd_pulse, conflict} === 2'b00) else begin
            n_fail++;
            $error("FAIL %s_strobes: got cmd=%b conflict=%b, expected 0 0", tag, cmd_pulse, conflict);
        end
    endtask

    task automatic expect_sr(input logic s);
        exp_t e;
        e.at = cyc + LAT;
        e.s  = s;
        exp_cmd.push_back(e);
    endtask

    task automatic drive_pattern(input logic [5:0] pat, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            btn_set = pat[i];
            step(1);
        end
        btn_set = 1'b0;
    endtask

    initial begin
        // Reset and idle
        btn_set = 1'b0;
        btn_rst = 1'b0;
        rst_n   = 1'b0;
        #2;
        check_reset_outputs("reset_immediate");
        step(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_sr("idle_hold", 1'b0);
        end

        // Clean set press, held 20 cycles, then released
        btn_set = 1'b1;
        expect_sr(1'b1);
        step(LAT - 1);
        check_sr("set_before_latency", 1'b0);
        step(1);
        check_sr("set_at_latency", 1'b1);
        step(20 - LAT);
        btn_set = 1'b0;
        step(12);
        check_sr("set_after_release", 1'b1);

        // Reset after set
        btn_rst = 1'b1;
        expect_sr(1'b0);
        step(10);
        btn_rst = 1'b0;
        step(12);
        check_sr("rst_after_set", 1'b0);

        // Bounce rejection: 1,0,1,1,1,0 then a 3-cycle pulse
        drive_pattern(6'b101110, 6);
        step(12);
        check_sr("bounce_rejected", 1'b0);
        drive_pattern(6'b000111, 3);
        step(12);
        check_sr("pulse3_rejected", 1'b0);

        // 4-cycle pulse is accepted
        expect_sr(1'b1);
        drive_pattern(6'b001111, 4);
        step(12);
        check_sr("pulse4_accepted", 1'b1);

        // Back to reset
        btn_rst = 1'b1;
        expect_sr(1'b0);
        step(10);
        btn_rst = 1'b0;
        step(12);
        check_sr("rst_again", 1'b0);

        // Conflict: reset held, then set pressed; release reset with set held
        btn_rst = 1'b1;
        step(10);
        btn_set = 1'b1;
        exp_cfl.push_back(cyc + LAT);
        step(10);
        check_sr("conflict_hold", 1'b0);
        btn_rst = 1'b0;
        step(15);
        check_sr("conflict_rst_released", 1'b0);
        btn_set = 1'b0;
        step(12);

        // Simultaneous press from SET_HELD
        btn_set = 1'b1;
        expect_sr(1'b1);
        step(10);
        btn_set = 1'b0;
        step(12);
        check_sr("sim_setup", 1'b1);
        btn_set = 1'b1;
        btn_rst = 1'b1;
        expect_sr(1'b0);
        exp_cfl.push_back(cyc + LAT);
        step(10);
        btn_set = 1'b0;
        btn_rst = 1'b0;
        step(12);
        check_sr("simultaneous", 1'b0);

        // Mid-cycle reset from SET_HELD with set still held
        btn_set = 1'b1;
        expect_sr(1'b1);
        step(10);
        check_sr("mid_reset_setup", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset_immediate");
        step(2);
        rst_n = 1'b1;
        expect_sr(1'b1);
        step(LAT - 1);
        check_sr("post_reset_before", 1'b0);
        step(1);
        check_sr("post_reset_set", 1'b1);
        btn_set = 1'b0;
        step(12);

        // Everything queued must have been seen
        n_tests++;
        assert (exp_cmd.size() === 0) else begin
            n_fail++;
            $error("FAIL cmd_queue_drained: got %0d pending, expected 0", exp_cmd.size());
        end
        n_tests++;
        assert (exp_cfl.size() === 0) else begin
            n_fail++;
            $error("FAIL conflict_queue_drained: got %0d pending, expected 0", exp_cfl.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
